fifo_write_scheduler: RTL and testbench
=======================================

Name: fifo_write_scheduler

Overview:
Shares the write side of the layer-RAM dual-clock write FIFO between two bus requesters and an internal fill engine. The fill engine writes a constant value over an address range, used to clear RAM during vblank. A single registered output stage drives the FIFO enqueue port (valid/ready, wr/addr/din). The block sits entirely in the write-clock domain.

Parameters:
ADDR_WIDTH, 17, write address width
DATA_WIDTH, 16, write data width

Ports:
clock  in  1  write-domain clock
reset  in  1  synchronous, active-high reset
io_in0_valid / io_in0_ready  in / out  1 / 1  requester 0 handshake
io_in0_bits_wr  in  1  requester 0 write flag
io_in0_bits_addr  in  ADDR_WIDTH  requester 0 address
io_in0_bits_din  in  DATA_WIDTH  requester 0 data
io_in1_valid, io_in1_ready, io_in1_bits_wr, io_in1_bits_addr, io_in1_bits_din  same as io_in0_*  requester 1
io_clear_start  in  1  pulse: start fill
io_clear_base  in  ADDR_WIDTH  fill start address
io_clear_count  in  ADDR_WIDTH+1  number of words to write
io_clear_value  in  DATA_WIDTH  fill data
io_clear_busy  out  1  fill engine active
io_clear_done  out  1  one-cycle pulse when fill completes
io_out_valid / io_out_ready  out / in  1 / 1  to FIFO enqueue valid / enqueue ready
io_out_bits_wr, io_out_bits_addr, io_out_bits_din  out  1, ADDR_WIDTH, DATA_WIDTH  to FIFO enqueue payload

Behaviour:
- Reset values:
  - io_out_valid=0; io_out_bits_* = 0.
  - io_clear_busy=0; io_clear_done=0.
  - Round-robin pointer favours in0.
  - All ready outputs are 0 during reset.
- Output stage: one register slot. load = !io_out_valid || io_out_ready.
  - On load with a grant: slot takes the granted payload and io_out_valid=1 next cycle.
  - On load with no grant: io_out_valid=0.
  - Latency is 1 cycle from input handshake to io_out_valid. Sustains 1 word/cycle when io_out_ready is held high.
- Arbitration (combinational, evaluated each cycle):
  - in0 vs in1: round-robin. Pointer toggles to the other requester only after a grant to the favoured one. A lone valid requester is granted regardless of the pointer.
  - Fill engine is granted only when busy and neither in0 nor in1 is valid.
  - io_inK_ready = load && grant==K. Only one input handshakes per cycle.
  - Payload is never modified; the wr flag passes through unchanged.
- Fill engine (states IDLE, FILL, DONE):
  - IDLE: on io_clear_start, latch base, count and value.
    - count>0: go to FILL, busy=1.
    - count==0: go to DONE, no writes issued.
  - FILL: offers wr=1, addr=cur, din=value.
    - Each accepted fill word: cur=cur+1 modulo 2^ADDR_WIDTH (wraps), remaining-1.
    - When remaining hits 0 on acceptance: go to DONE, busy=0 the next cycle.
  - DONE: io_clear_done=1 for exactly one cycle, then IDLE.
  - io_clear_start is ignored in FILL and DONE. A start coincident with a DONE cycle is also ignored.
- io_out_bits_* hold stable while io_out_valid && !io_out_ready.
- Reset mid-operation: pending slot and fill are discarded; no done pulse.

Optional Feature:
Macro: FIFO_WRITE_SCHEDULER_STATS_EN
- Defined: adds ports io_stat_clear (in, 1) and io_stat_in0, io_stat_in1, io_stat_fill (out, 16 each).
  - Each counter counts grants to its source and saturates at 0xFFFF.
  - io_stat_clear or reset zeroes all three counters. A grant in the same cycle as a clear is not counted.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- in0 and in1 both valid continuously, io_out_ready=1, in0 addr=0x00010, in1 addr=0x00020 -> out addresses alternate 0x00010, 0x00020, 0x00010…; first io_out_valid one cycle after the first handshake; 1 word/cycle.
- Only in1 valid with pointer favouring in0 -> in1 granted immediately; io_in0_ready=0.
- io_out_ready=0 for 3 cycles with slot full -> io_out_bits stable, both io_inK_ready=0, no words lost; resumes on ready.
- clear_start base=0x1FFFE, count=4, value=0xABCD, no requesters -> writes to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 with din=0xABCD, wr=1; busy for 4 accepted words; one done pulse.
- Fill in progress while in0 asserts valid for 2 cycles -> those 2 in0 words interleave ahead of fill; fill total remains exactly count words; start pulse during FILL ignored.
- clear_start with count=0 -> no output writes; done pulse on the following cycle. Reset asserted mid-fill -> out_valid=0, busy=0, no done pulse.

Source files
------------

// File: rtl/fifo_write_scheduler_if.sv
// Write-side bus bundle for fifo_write_scheduler: two requester ports, the
// fill-engine control, and the FIFO enqueue port.
// slave  : the scheduler's view of the bundle.
// master : the surrounding environment's view (requesters + FIFO).
// Optional statistics signals exist only when FIFO_WRITE_SCHEDULER_STATS_EN is defined.
interface fifo_write_scheduler_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
);
    logic                  io_in0_valid;
    logic                  io_in0_ready;
    logic                  io_in0_bits_wr;
    logic [ADDR_WIDTH-1:0] io_in0_bits_addr;
    logic [DATA_WIDTH-1:0] io_in0_bits_din;

    logic                  io_in1_valid;
    logic                  io_in1_ready;
    logic                  io_in1_bits_wr;
    logic [ADDR_WIDTH-1:0] io_in1_bits_addr;
    logic [DATA_WIDTH-1:0] io_in1_bits_din;

    logic                  io_clear_start;
    logic [ADDR_WIDTH-1:0] io_clear_base;
    logic [ADDR_WIDTH:0]   io_clear_count;
    logic [DATA_WIDTH-1:0] io_clear_value;
    logic                  io_clear_busy;
    logic                  io_clear_done;

    logic                  io_out_valid;
    logic                  io_out_ready;
    logic                  io_out_bits_wr;
    logic [ADDR_WIDTH-1:0] io_out_bits_addr;
    logic [DATA_WIDTH-1:0] io_out_bits_din;

`ifdef FIFO_WRITE_SCHEDULER_STATS_EN
    logic                  io_stat_clear;
    logic [15:0]           io_stat_in0;
    logic [15:0]           io_stat_in1;
    logic [15:0]           io_stat_fill;

    modport slave (
        input  io_in0_valid, io_in0_bits_wr, io_in0_bits_addr, io_in0_bits_din,
        output io_in0_ready,
        input  io_in1_valid, io_in1_bits_wr, io_in1_bits_addr, io_in1_bits_din,
        output io_in1_ready,
        input  io_clear_start, io_clear_base, io_clear_count, io_clear_value,
        output io_clear_busy, io_clear_done,
        output io_out_valid, io_out_bits_wr, io_out_bits_addr, io_out_bits_din,
        input  io_out_ready,
        input  io_stat_clear,
        output io_stat_in0, io_stat_in1, io_stat_fill
    );

    modport master (
        output io_in0_valid, io_in0_bits_wr, io_in0_bits_addr, io_in0_bits_din,
        input  io_in0_ready,
        output io_in1_valid, io_in1_bits_wr, io_in1_bits_addr, io_in1_bits_din,
        input  io_in1_ready,
        output io_clear_start, io_clear_base, io_clear_count, io_clear_value,
        input  io_clear_busy, io_clear_done,
        input  io_out_valid, io_out_bits_wr, io_out_bits_addr, io_out_bits_din,
        output io_out_ready,
        output io_stat_clear,
        input  io_stat_in0, io_stat_in1, io_stat_fill
    );
`else
    modport slave (
        input  io_in0_valid, io_in0_bits_wr, io_in0_bits_addr, io_in0_bits_din,
        output io_in0_ready,
        input  io_in1_valid, io_in1_bits_wr, io_in1_bits_addr, io_in1_bits_din,
        output io_in1_ready,
        input  io_clear_start, io_clear_base, io_clear_count, io_clear_value,
        output io_clear_busy, io_clear_done,
        output io_out_valid, io_out_bits_wr, io_out_bits_addr, io_out_bits_din,
        input  io_out_ready
    );

    modport master (
        output io_in0_valid, io_in0_bits_wr, io_in0_bits_addr, io_in0_bits_din,
        input  io_in0_ready,
        output io_in1_valid, io_in1_bits_wr, io_in1_bits_addr, io_in1_bits_din,
        input  io_in1_ready,
        output io_clear_start, io_clear_base, io_clear_count, io_clear_value,
        input  io_clear_busy, io_clear_done,
        input  io_out_valid, io_out_bits_wr, io_out_bits_addr, io_out_bits_din,
        output io_out_ready
    );
`endif
endinterface

// File: rtl/fifo_write_scheduler.sv
// fifo_write_scheduler: shares the write side of the layer-RAM write FIFO
// between two bus requesters (round-robin) and a constant-fill engine used to
// clear RAM during vblank. One registered output slot drives the enqueue port.
// Optional grant counters are built when FIFO_WRITE_SCHEDULER_STATS_EN is defined.
module fifo_write_scheduler #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    fifo_write_scheduler_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Output slot
    logic                  out_valid_q, out_valid_d;
    logic                  out_wr_q,    out_wr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [DATA_WIDTH-1:0] out_din_q,   out_din_d;

    // Round-robin pointer: 0 favours in0, 1 favours in1
    logic                  rr_q, rr_d;

    // Fill engine
    logic [1:0]            fsm_q, fsm_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;

    // Arbitration results
    logic load_s;
    logic gnt0_s, gnt1_s, gntf_s;
    logic take0_s, take1_s, takef_s;

    assign load_s  = !out_valid_q || bus.io_out_ready;
    // Handshakes are suppressed while reset is held so no ready leaks out.
    assign take0_s = load_s && gnt0_s && !reset;
    assign take1_s = load_s && gnt1_s && !reset;
    assign takef_s = load_s && gntf_s && !reset;

    assign bus.io_in0_ready     = take0_s;
    assign bus.io_in1_ready     = take1_s;
    assign bus.io_out_valid     = out_valid_q;
    assign bus.io_out_bits_wr   = out_wr_q;
    assign bus.io_out_bits_addr = out_addr_q;
    assign bus.io_out_bits_din  = out_din_q;
    assign bus.io_clear_busy    = (fsm_q == ST_FILL);
    assign bus.io_clear_done    = (fsm_q == ST_DONE);

    // Arbitration: requesters first (round-robin on contention), fill only when both idle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        gntf_s = 1'b0;
        if (bus.io_in0_valid && bus.io_in1_valid) begin
            if (rr_q) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (bus.io_in0_valid) begin
            gnt0_s = 1'b1;
        end else if (bus.io_in1_valid) begin
            gnt1_s = 1'b1;
        end else if (fsm_q == ST_FILL) begin
            gntf_s = 1'b1;
        end else begin
            gntf_s = 1'b0;
        end
    end

    // Pointer moves away from a requester only after that favoured requester was served.
    always_comb begin
        rr_d = rr_q;
        if (take0_s && !rr_q) begin
            rr_d = 1'b1;
        end else if (take1_s && rr_q) begin
            rr_d = 1'b0;
        end else begin
            rr_d = rr_q;
        end
    end

    // Output slot: reload when empty or drained; payload copied untouched from the winner.
    always_comb begin
        out_valid_d = out_valid_q;
        out_wr_d    = out_wr_q;
        out_addr_d  = out_addr_q;
        out_din_d   = out_din_q;
        if (load_s) begin
            out_valid_d = take0_s || take1_s || takef_s;
            if (take0_s) begin
                out_wr_d   = bus.io_in0_bits_wr;
                out_addr_d = bus.io_in0_bits_addr;
                out_din_d  = bus.io_in0_bits_din;
            end else if (take1_s) begin
                out_wr_d   = bus.io_in1_bits_wr;
                out_addr_d = bus.io_in1_bits_addr;
                out_din_d  = bus.io_in1_bits_din;
            end else if (takef_s) begin
                out_wr_d   = 1'b1;
                out_addr_d = cur_q;
                out_din_d  = val_q;
            end else begin
                out_wr_d   = out_wr_q;
                out_addr_d = out_addr_q;
                out_din_d  = out_din_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Fill engine: latch job on start in IDLE, emit one word per accepted grant, pulse done.
    always_comb begin
        fsm_d = fsm_q;
        cur_d = cur_q;
        rem_d = rem_q;
        val_d = val_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.io_clear_start) begin
                    cur_d = bus.io_clear_base;
                    rem_d = bus.io_clear_count;
                    val_d = bus.io_clear_value;
                    if (bus.io_clear_count != '0) begin
                        fsm_d = ST_FILL;
                    end else begin
                        fsm_d = ST_DONE;
                    end
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (takef_s) begin
                    cur_d = cur_q + ADDR_WIDTH'(1);
                    rem_d = rem_q - (ADDR_WIDTH + 1)'(1);
                    if (rem_q == (ADDR_WIDTH + 1)'(1)) begin
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d = ST_FILL;
                    end
                end else begin
                    fsm_d = ST_FILL;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_wr_q    <= 1'b0;
            out_addr_q  <= '0;
            out_din_q   <= '0;
            rr_q        <= 1'b0;
            fsm_q       <= ST_IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            val_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_wr_q    <= out_wr_d;
            out_addr_q  <= out_addr_d;
            out_din_q   <= out_din_d;
            rr_q        <= rr_d;
            fsm_q       <= fsm_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            val_q       <= val_d;
        end
    end

`ifdef FIFO_WRITE_SCHEDULER_STATS_EN
    // Saturating increment used by the grant counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    logic [15:0] st0_q, st0_d;
    logic [15:0] st1_q, st1_d;
    logic [15:0] stf_q, stf_d;

    assign bus.io_stat_in0  = st0_q;
    assign bus.io_stat_in1  = st1_q;
    assign bus.io_stat_fill = stf_q;

    // Grant counters; a clear wins over a same-cycle grant.
    always_comb begin
        st0_d = st0_q;
        st1_d = st1_q;
        stf_d = stf_q;
        if (bus.io_stat_clear) begin
            st0_d = 16'd0;
            st1_d = 16'd0;
            stf_d = 16'd0;
        end else begin
            st0_d = sat_inc(st0_q, take0_s);
            st1_d = sat_inc(st1_q, take1_s);
            stf_d = sat_inc(stf_q, takef_s);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            st0_q <= 16'd0;
            st1_q <= 16'd0;
            stf_q <= 16'd0;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
            stf_q <= stf_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Directed bench for fifo_write_scheduler: a vector table for arbitration and
// stall behaviour, plus hand-written sequences for fill, count=0 and mid-fill reset.
module tb_fifo_write_scheduler;

    localparam int AW = 17;
    localparam int DW = 16;

    logic clock;
    logic reset;

    fifo_write_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fifo_write_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } word_t;

    word_t mon_q[$];
    int    done_cnt;
    int    busy_cnt;
    logic  mon_en = 1'b0;

    // Record accepted output words and status pulses at the falling edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.io_out_valid && bus.io_out_ready) begin
                mon_q.push_back('{wr: bus.io_out_bits_wr, addr: bus.io_out_bits_addr,
                                  din: bus.io_out_bits_din});
            end
            if (bus.io_clear_done) done_cnt++;
            if (bus.io_clear_busy) busy_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_start();
        mon_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        mon_en   = 1'b1;
    endtask

    typedef struct {
        logic          v0;
        logic          v1;
        logic          ordy;
        logic          e_r0;
        logic          e_r1;
        logic          e_ov;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vt[12];

    function automatic vec_t mk(logic v0, logic v1, logic ordy, logic r0, logic r1,
                                logic ov, logic [AW-1:0] a);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.ordy = ordy;
        v.e_r0 = r0; v.e_r1 = r1; v.e_ov = ov; v.e_addr = a;
        return v;
    endfunction

    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic          exp_w;

    initial begin
        // Table: v0 v1 ordy | ready0 ready1 | out_valid out_addr (after the edge)
        vt[0]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00010);
        vt[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h00020);
        vt[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00010);
        vt[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h00020);
        vt[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h00020);
        vt[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h00000);
        vt[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00010);
        vt[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00010);
        vt[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00010);
        vt[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00010);
        vt[10] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 17'h00020);
        vt[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h00000);

        // Reset with requesters active: nothing may handshake.
        reset = 1'b1;
        bus.io_in0_valid = 1'b1; bus.io_in0_bits_wr = 1'b1;
        bus.io_in0_bits_addr = 17'h00010; bus.io_in0_bits_din = 16'h1111;
        bus.io_in1_valid = 1'b1; bus.io_in1_bits_wr = 1'b0;
        bus.io_in1_bits_addr = 17'h00020; bus.io_in1_bits_din = 16'h2222;
        bus.io_clear_start = 1'b0; bus.io_clear_base = 17'h00000;
        bus.io_clear_count = 18'h00000; bus.io_clear_value = 16'h0000;
        bus.io_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in0_ready", {31'd0, bus.io_in0_ready}, 32'd0);
        chk("rst_in1_ready", {31'd0, bus.io_in1_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("rst_out_wr", {31'd0, bus.io_out_bits_wr}, 32'd0);
        chk("rst_out_addr", {15'd0, bus.io_out_bits_addr}, 32'd0);
        chk("rst_out_din", {16'd0, bus.io_out_bits_din}, 32'd0);
        chk("rst_busy", {31'd0, bus.io_clear_busy}, 32'd0);
        chk("rst_done", {31'd0, bus.io_clear_done}, 32'd0);
        @(negedge clock); #2;
        reset = 1'b0;
        bus.io_in0_valid = 1'b0;
        bus.io_in1_valid = 1'b0;

        // Arbitration, lone requester and stall vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock); #2;
            bus.io_in0_valid = vt[i].v0;
            bus.io_in1_valid = vt[i].v1;
            bus.io_out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_in0_ready", i), {31'd0, bus.io_in0_ready}, {31'd0, vt[i].e_r0});
            chk($sformatf("v%0d_in1_ready", i), {31'd0, bus.io_in1_ready}, {31'd0, vt[i].e_r1});
            @(posedge clock); #1;
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus.io_out_valid}, {31'd0, vt[i].e_ov});
            if (vt[i].e_ov) begin
                exp_d = (vt[i].e_addr == 17'h00010) ? 16'h1111 : 16'h2222;
                exp_w = (vt[i].e_addr == 17'h00010) ? 1'b1 : 1'b0;
                chk($sformatf("v%0d_out_addr", i), {15'd0, bus.io_out_bits_addr}, {15'd0, vt[i].e_addr});
                chk($sformatf("v%0d_out_din", i), {16'd0, bus.io_out_bits_din}, {16'd0, exp_d});
                chk($sformatf("v%0d_out_wr", i), {31'd0, bus.io_out_bits_wr}, {31'd0, exp_w});
            end
        end

        // Fill across the address wrap, no requesters.
        @(negedge clock); #2;
        mon_start();
        bus.io_out_ready = 1'b1;
        bus.io_clear_start = 1'b1; bus.io_clear_base = 17'h1FFFE;
        bus.io_clear_count = 18'd4; bus.io_clear_value = 16'hABCD;
        @(negedge clock); #2;
        bus.io_clear_start = 1'b0;
        repeat (10) @(negedge clock);
        mon_en = 1'b0;
        chk("wrap_words", mon_q.size(), 32'd4);
        chk("wrap_busy_cycles", busy_cnt, 32'd4);
        chk("wrap_done_pulses", done_cnt, 32'd1);
        exp_a = 17'h1FFFE;
        for (int i = 0; i < mon_q.size(); i++) begin
            chk($sformatf("wrap_addr%0d", i), {15'd0, mon_q[i].addr}, {15'd0, exp_a});
            chk($sformatf("wrap_din%0d", i), {16'd0, mon_q[i].din}, 32'h0000ABCD);
            chk($sformatf("wrap_wr%0d", i), {31'd0, mon_q[i].wr}, 32'd1);
            exp_a = exp_a + 17'd1;
        end

        // Fill with two in0 words cutting in and an ignored restart during FILL.
        @(negedge clock); #2;
        mon_start();
        bus.io_clear_start = 1'b1; bus.io_clear_base = 17'h00100;
        bus.io_clear_count = 18'd3; bus.io_clear_value = 16'h5A5A;
        @(negedge clock); #2;
        bus.io_clear_base = 17'h00200; bus.io_clear_count = 18'd7;
        bus.io_in0_valid = 1'b1; bus.io_in0_bits_addr = 17'h00030; bus.io_in0_bits_din = 16'h3030;
        @(negedge clock); #2;
        bus.io_clear_start = 1'b0;
        bus.io_in0_bits_addr = 17'h00031; bus.io_in0_bits_din = 16'h3131;
        @(negedge clock); #2;
        bus.io_in0_valid = 1'b0;
        repeat (12) @(negedge clock);
        mon_en = 1'b0;
        chk("mix_words", mon_q.size(), 32'd5);
        chk("mix_done_pulses", done_cnt, 32'd1);
        for (int i = 0; i < mon_q.size() && i < 5; i++) begin
            case (i)
                0: begin exp_a = 17'h00030; exp_d = 16'h3030; end
                1: begin exp_a = 17'h00031; exp_d = 16'h3131; end
                default: begin exp_a = 17'h00100 + 17'(i - 2); exp_d = 16'h5A5A; end
            endcase
            chk($sformatf("mix_addr%0d", i), {15'd0, mon_q[i].addr}, {15'd0, exp_a});
            chk($sformatf("mix_din%0d", i), {16'd0, mon_q[i].din}, {16'd0, exp_d});
        end

        // Count of zero: no writes, done on the following cycle only.
        @(negedge clock); #2;
        mon_start();
        bus.io_clear_start = 1'b1; bus.io_clear_base = 17'h00050;
        bus.io_clear_count = 18'd0; bus.io_clear_value = 16'h7777;
        @(posedge clock); #1;
        chk("zero_done_first", {31'd0, bus.io_clear_done}, 32'd1);
        chk("zero_busy", {31'd0, bus.io_clear_busy}, 32'd0);
        bus.io_clear_start = 1'b0;
        @(posedge clock); #1;
        chk("zero_done_second", {31'd0, bus.io_clear_done}, 32'd0);
        repeat (3) @(negedge clock);
        mon_en = 1'b0;
        chk("zero_words", mon_q.size(), 32'd0);
        chk("zero_done_pulses", done_cnt, 32'd1);

        // Reset in the middle of a long fill.
        @(negedge clock); #2;
        bus.io_clear_start = 1'b1; bus.io_clear_base = 17'h00040;
        bus.io_clear_count = 18'd10; bus.io_clear_value = 16'h1234;
        @(negedge clock); #2;
        bus.io_clear_start = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        chk("midfill_busy_before", {31'd0, bus.io_clear_busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midfill_out_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("midfill_busy", {31'd0, bus.io_clear_busy}, 32'd0);
        chk("midfill_done", {31'd0, bus.io_clear_done}, 32'd0);
        @(negedge clock); #2;
        reset = 1'b0;
        mon_start();
        repeat (6) @(negedge clock);
        mon_en = 1'b0;
        chk("post_reset_words", mon_q.size(), 32'd0);
        chk("post_reset_done", done_cnt, 32'd0);
        chk("post_reset_busy", busy_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
